// File: rtl/raster_scan_writer_if.sv
// Pixel stream between the raster scanner, the object draw-flag decoders and the LCD writer.
// The master drives the scan position and colour. The slave side returns the draw flags and the ready signal.
interface raster_scan_writer_if;
  logic [7:0]  xCount;
  logic [8:0]  yCount;
  logic        pixelWrite;
  logic [15:0] pixelData;
  logic        pixelReady;
  logic        drawPaddle;
  logic        drawBall;

  modport master (
    output xCount, yCount, pixelWrite, pixelData,
    input  pixelReady, drawPaddle, drawBall
  );

  modport slave (
    input  xCount, yCount, pixelWrite, pixelData,
    output pixelReady, drawPaddle, drawBall
  );
endinterface

// File: rtl/raster_scan_writer.sv
// Row-major raster scanner. It composites the paddle and ball flags into RGB565 and streams each pixel over valid/ready.
// A frameDone pulse follows the last accepted pixel and paces the game logic.
//
// state | meaning
// IDLE  | counters parked at (0,0), waiting for frameStart
// SCAN  | presenting pixels, advancing on each accepted transfer
// DONE  | single-cycle frameDone pulse, then back to IDLE
module raster_scan_writer #(
  parameter int          WIDTH         = 240,
  parameter int          HEIGHT        = 320,
  parameter logic [15:0] BG_COLOUR     = 16'h0000,
  parameter logic [15:0] PADDLE_COLOUR = 16'hFFFF,
  parameter logic [15:0] BALL_COLOUR   = 16'hF800
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 frameStart_i,
  raster_scan_writer_if.master pix,
  output logic                 scanBusy_o,
  output logic                 frameDone_o
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       wr_q, wr_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       xfer;

  assign xfer = wr_q & pix.pixelReady;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (frameStart_i) state_d = SCAN;
      end
      SCAN: begin
        if (xfer) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
              y_d     = '0;
              state_d = DONE;
            end else begin
              y_d = y_q + 9'd1;
            end
          end else begin
            x_d = x_q + 8'd1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Status flags are decoded from the next state so that they leave registers aligned with the state.
    wr_d   = (state_d == SCAN);
    busy_d = (state_d == SCAN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pix.xCount     = x_q;
  assign pix.yCount     = y_q;
  assign pix.pixelWrite = wr_q;
  assign scanBusy_o     = busy_q;
  assign frameDone_o    = done_q;

  // The ball is drawn over the paddle. The background colour is shown whenever no pixel is being offered.
  assign pix.pixelData = !wr_q         ? BG_COLOUR     :
                         pix.drawBall   ? BALL_COLOUR   :
                         pix.drawPaddle ? PADDLE_COLOUR : BG_COLOUR;

endmodule

// File: tb/tb_raster_scan_writer.sv
// Bench for raster_scan_writer. The frame height is shortened to 52 lines so that three frames stay within the cycle budget.
// The full 240-pixel line width is kept, and row 50 can still be reached.
module tb_raster_scan_writer;
  localparam int W    = 240;
  localparam int H    = 52;
  localparam int NPIX = W * H;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic frameStart = 1'b0;
  logic scanBusy, frameDone;

  raster_scan_writer_if bus();

  raster_scan_writer #(
    .WIDTH(W), .HEIGHT(H),
    .BG_COLOUR(16'h0000), .PADDLE_COLOUR(16'hFFFF), .BALL_COLOUR(16'hF800)
  ) dut (
    .clock(clock), .reset(reset), .frameStart_i(frameStart),
    .pix(bus.master), .scanBusy_o(scanBusy), .frameDone_o(frameDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          pad;
    bit          bal;
    logic [15:0] exp;
  } vec_t;
  vec_t vecs[4];

  int total = 0;
  int bad   = 0;

  // Reference model: a frame is a count of accepted pixels. The position is derived from that count with div/mod.
  bit m_busy = 0;
  bit m_done = 0;
  int m_n    = 0;

  int cyc = 0;
  int xfer_cnt, done_cnt, last_x, last_y, last_xfer_cyc, done_cyc;

  task automatic summary_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      if (bad >= 50) summary_and_finish();
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: cycle budget expired (cycle %0d)", name, cyc);
  endtask

  function automatic int colour(input bit p, input bit b);
    if (b) return 32'hF800;
    if (p) return 32'hFFFF;
    return 0;
  endfunction

  task automatic clear_stats();
    xfer_cnt = 0; done_cnt = 0; last_x = -1; last_y = -1;
    last_xfer_cyc = -1; done_cyc = -1;
  endtask

  // Called just after a falling edge. It drives inputs, checks against the model, then advances the model by one clock.
  task automatic step(input bit st, input bit rdy, input bit pad, input bit bal);
    frameStart = st;
    bus.pixelReady = rdy;
    bus.drawPaddle = pad;
    bus.drawBall = bal;
    #1;
    chk("xCount",     int'(bus.xCount),     m_busy ? m_n % W : 0);
    chk("yCount",     int'(bus.yCount),     m_busy ? m_n / W : 0);
    chk("pixelWrite", int'(bus.pixelWrite), int'(m_busy));
    chk("scanBusy",   int'(scanBusy),       int'(m_busy));
    chk("frameDone",  int'(frameDone),      int'(m_done));
    chk("pixelData",  int'(bus.pixelData),  m_busy ? colour(pad, bal) : 0);
    if (bus.pixelWrite && rdy) begin
      xfer_cnt++;
      last_x = bus.xCount;
      last_y = bus.yCount;
      last_xfer_cyc = cyc;
    end
    if (frameDone) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (m_done) m_done = 0;
    else if (m_busy) begin
      if (rdy) begin
        m_n++;
        if (m_n == NPIX) begin
          m_n = 0; m_busy = 0; m_done = 1;
        end
      end
    end else if (st) m_busy = 1;
    @(negedge clock);
    cyc++;
  endtask

  task automatic step_r(input bit st, input bit rdy);
    step(st, rdy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  initial begin
    int  guard;
    bit  arm, st, stall5, colour_done, aborted;

    vecs[0] = '{pad: 1'b1, bal: 1'b0, exp: 16'hFFFF};
    vecs[1] = '{pad: 1'b1, bal: 1'b1, exp: 16'hF800};
    vecs[2] = '{pad: 1'b0, bal: 1'b0, exp: 16'h0000};
    vecs[3] = '{pad: 1'b0, bal: 1'b1, exp: 16'hF800};

    bus.pixelReady = 1'b0;
    bus.drawPaddle = 1'b0;
    bus.drawBall   = 1'b0;

    // Reset, then idle with no frameStart.
    #1;
    chk("rst_x",    int'(bus.xCount),     0);
    chk("rst_y",    int'(bus.yCount),     0);
    chk("rst_wr",   int'(bus.pixelWrite), 0);
    chk("rst_busy", int'(scanBusy),       0);
    chk("rst_done", int'(frameDone),      0);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    clear_stats();
    repeat (10) step_r(0, 1);
    chk("idle_done_cnt", done_cnt, 0);

    // Frame A: ready held high. A frameStart arrives mid-scan, and the line wrap is checked.
    clear_stats();
    step_r(1, 1);
    guard = 0;
    while ((m_busy || m_done) && guard < NPIX + 100) begin
      arm = m_busy && (m_n == W - 1);
      st  = m_busy && (m_n == 50 * W + 100);
      step_r(st, 1);
      if (arm) begin
        chk("wrap_x", int'(bus.xCount), 0);
        chk("wrap_y", int'(bus.yCount), 1);
      end
      guard++;
    end
    if (m_busy || m_done) timeout("frameA_budget");
    chk("A_xfers",    xfer_cnt, NPIX);
    chk("A_last_x",   last_x,   W - 1);
    chk("A_last_y",   last_y,   H - 1);
    chk("A_done_cnt", done_cnt, 1);
    chk("A_done_lag", done_cyc - last_xfer_cyc, 1);
    step_r(0, 1);
    chk("A_idle_x", int'(bus.xCount), 0);
    chk("A_idle_y", int'(bus.yCount), 0);

    // Frame B: ready alternates. There is a 20-cycle stall at (5,0) and a colour table at (105,5), and frameStart is driven during DONE.
    clear_stats();
    step_r(1, 1);
    guard = 0; stall5 = 0; colour_done = 0;
    while ((m_busy || m_done) && guard < 2 * NPIX + 200) begin
      if (!stall5 && m_busy && m_n == 5) begin
        stall5 = 1;
        repeat (20) begin
          step_r(0, 0);
          chk("stall_x",  int'(bus.xCount),     5);
          chk("stall_wr", int'(bus.pixelWrite), 1);
        end
      end else if (!colour_done && m_busy && m_n == 5 * W + 105) begin
        colour_done = 1;
        for (int i = 0; i < 4; i++) begin
          step(0, 0, vecs[i].pad, vecs[i].bal);
          chk("colour_x",    int'(bus.xCount),    105);
          chk("colour_y",    int'(bus.yCount),    5);
          chk("colour_data", int'(bus.pixelData), int'(vecs[i].exp));
        end
      end else begin
        step_r(m_done, (cyc % 2) == 0);
      end
      guard++;
    end
    if (m_busy || m_done) timeout("frameB_budget");
    chk("B_stall_seen",  int'(stall5),      1);
    chk("B_colour_seen", int'(colour_done), 1);
    chk("B_xfers",       xfer_cnt,          NPIX);
    chk("B_done_cnt",    done_cnt,          1);
    step_r(0, 1);
    chk("B_no_restart", int'(scanBusy), 0);

    // Frame C: ready is random. Reset is asserted at (100,50) and must abort the frame at once.
    clear_stats();
    step_r(1, 1);
    guard = 0; aborted = 0;
    while (!aborted && m_busy && guard < 4 * NPIX) begin
      if (m_n == 50 * W + 100) begin
        aborted = 1;
        chk("C_pre_x", int'(bus.xCount), 100);
        chk("C_pre_y", int'(bus.yCount), 50);
        reset = 1'b0;
        #1;
        chk("abort_x",    int'(bus.xCount),     0);
        chk("abort_y",    int'(bus.yCount),     0);
        chk("abort_wr",   int'(bus.pixelWrite), 0);
        chk("abort_busy", int'(scanBusy),       0);
        chk("abort_done", int'(frameDone),      0);
        m_busy = 0; m_done = 0; m_n = 0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
      end else begin
        step_r(0, $urandom_range(0, 3) != 0);
      end
      guard++;
    end
    if (!aborted) timeout("frameC_budget");
    done_cnt = 0;
    repeat (12) step_r(0, 1);
    chk("C_no_done", done_cnt, 0);

    summary_and_finish();
  end
endmodule

// File: doc/raster_scan_writer.md
Name: raster_scan_writer

Overview:
- Generates the xCount/yCount raster scan that the game object blocks (paddle, ball) decode into draw flags.
- Composites those draw flags into one colour per pixel.
- Streams the result to the LCD pixel writer over a valid/ready handshake.
- Sits between the object blocks and the LCD driver, and produces a frame-done pulse that paces game logic updates.

Parameters:
- WIDTH, 240, pixels per line; xCount range is 0..WIDTH-1.
- HEIGHT, 320, lines per frame; yCount range is 0..HEIGHT-1.
- BG_COLOUR, 16'h0000, RGB565 background colour.
- PADDLE_COLOUR, 16'hFFFF, RGB565 colour when drawPaddle is high.
- BALL_COLOUR, 16'hF800, RGB565 colour when drawBall is high.

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-low reset.
- frameStart  in  1  one-cycle request to begin scanning a frame.
- drawPaddle  in  1  paddle-pixel flag, combinational from xCount/yCount.
- drawBall  in  1  ball-pixel flag, combinational from xCount/yCount.
- pixelReady  in  1  LCD writer can accept a pixel this cycle.
- xCount  out  8  current pixel column.
- yCount  out  9  current pixel row.
- pixelWrite  out  1  pixelData/xCount/yCount are valid.
- pixelData  out  16  RGB565 colour for the current pixel.
- scanBusy  out  1  high while a frame is being scanned.
- frameDone  out  1  one-cycle pulse after the last pixel is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; xCount=0, yCount=0.
  - pixelWrite=0, scanBusy=0, frameDone=0.
  - pixelData is BG_COLOUR whenever pixelWrite=0.
- FSM states are IDLE, SCAN, DONE.
- IDLE:
  - Counters are held at 0, 0.
  - frameStart=1 on a clock edge moves the FSM to SCAN on the next cycle. pixelWrite and scanBusy go high in that cycle.
- SCAN:
  - pixelWrite=1 and scanBusy=1.
  - pixelData is combinational: drawBall ? BALL_COLOUR : drawPaddle ? PADDLE_COLOUR : BG_COLOUR. Ball has priority over paddle.
  - Transfer occurs on a clock edge with pixelWrite && pixelReady.
  - Without a transfer, xCount, yCount and pixelWrite hold. There is no limit on how long pixelReady may stay low.
  - On transfer with xCount<WIDTH-1: xCount increments.
  - On transfer with xCount==WIDTH-1 and yCount<HEIGHT-1: xCount becomes 0 and yCount increments.
  - On transfer with xCount==WIDTH-1 and yCount==HEIGHT-1: go to DONE, xCount becomes 0, yCount becomes 0, pixelWrite becomes 0.
- DONE:
  - Lasts exactly one cycle, with frameDone=1 and scanBusy=0.
  - Then returns to IDLE.
- frameStart is ignored in SCAN and in DONE. There is no queuing; a frameStart that arrives during a scan is dropped.
- Counts per frame:
  - Exactly WIDTH*HEIGHT = 76800 transfers.
  - Every (x,y) pair appears exactly once, in row-major order.
  - xCount never exceeds WIDTH-1 and yCount never exceeds HEIGHT-1.
- Throughput: with pixelReady held at 1, one pixel per cycle. A frame takes 76800 SCAN cycles plus 1 DONE cycle.
- Reset mid-scan aborts immediately. Counters return to 0 and no frameDone is issued.
- All outputs except pixelData are registered. pixelData is the only combinational path, and depends only on the draw inputs.

Test Plan:
1. Reset with reset=0 for 5 cycles, then release. Required: xCount=0, yCount=0, pixelWrite=0, scanBusy=0 and frameDone=0. These stay unchanged for 10 cycles with no frameStart.
2. Pulse frameStart with pixelReady=1 throughout. Required:
   - Exactly 76800 transfers.
   - The last transfer is at (239,319).
   - frameDone pulses once, 1 cycle after that transfer.
   - Then IDLE with counters at (0,0).
3. Pulse frameStart, then drive pixelReady 1 and 0 on alternate cycles. Required:
   - Counters advance only on ready cycles.
   - At (5,0), holding pixelReady=0 for 20 cycles keeps xCount=5 and pixelWrite=1.
   - 76800 transfers total.
4. Colour mux with drawPaddle=1, drawBall=0 at xCount=105, yCount=5. Required:
   - pixelData=16'hFFFF.
   - With both flags high, pixelData=16'hF800.
   - With neither flag, pixelData=16'h0000.
5. Line wrap: at xCount=239, yCount=0 with pixelReady=1. Required: next cycle xCount=0, yCount=1.
6. Corner cases:
   - frameStart pulsed mid-scan at (100,50) has no effect; frame completes normally with a single frameDone.
   - reset=0 asserted at (100,50) gives immediate xCount=0, yCount=0, pixelWrite=0, and no frameDone.
